bcd_seq_ctrl: RTL and testbench
===============================

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 SHALL have parameter: LAP_W, 4, width of lap target/counter.
REQ-002 SHALL have ports, one clock; reset is synchronous and active-high:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous, active-high reset
  start  in  1  begin sequence; samples mode, dir, lap_target
  stop  in  1  abort to IDLE
  mode  in  2  00 odd>3 {5,7,9}; 01 odd {1,3,5,7,9}; 10 even {0,2,4,6,8}; 11 full {0..9}
  dir  in  1  0 ascending, 1 descending
  lap_target  in  LAP_W  laps before DONE; 0 = run forever
  out_ready  in  1  consumer accepts count
  count  out  4  current BCD value
  out_valid  out  1  count valid for transfer
  wrap  out  1  one-cycle pulse on wrap-around
  busy  out  1  high in RUN
  done  out  1  high in DONE
  lap_cnt  out  LAP_W  completed laps

Function
REQ-003 SHALL implement FSM states IDLE, RUN, DONE.
REQ-004 SHALL, in IDLE, drive out_valid=0, busy=0, done=0, and hold count and lap_cnt.
REQ-005 SHALL, on start in IDLE or DONE, latch mode/dir/lap_target, load count with the first value (lowest if dir=0, highest if dir=1), clear lap_cnt, and enter RUN next cycle.
REQ-006 SHALL ignore mode, dir and lap_target changes outside the start cycle.
REQ-007 SHALL, in RUN, assert out_valid=1 and busy=1, holding count stable until out_valid&&out_ready.
REQ-008 SHALL, on transfer, advance count to the next sequence member in dir, with one-cycle latency.
REQ-009 SHALL, on transfer of the last member (dir=0 highest, dir=1 lowest), load the first member, pulse wrap for exactly one cycle, and increment lap_cnt (modulo 2^LAP_W).
REQ-010 SHALL, when a wrap makes lap_cnt equal a non-zero lap_target, enter DONE instead of RUN, with count holding the last-transferred value, out_valid=0 and done=1.
REQ-011 SHALL give stop priority over transfer: a same-cycle handshake completes, but there is no advance or wrap, and the next state is IDLE with count held.
REQ-012 SHALL give start in RUN no effect; start and stop together in IDLE/DONE resolve to IDLE.
REQ-013 SHALL, if count is ever not a member of the latched sequence, load the first member on the next transfer, with no wrap.
REQ-014 SHALL keep count within 0..9 at all times.
REQ-015 SHALL, in DONE, leave only start or stop; stop returns to IDLE with count held.

Reset
REQ-016 SHALL, on reset at a clock edge, force IDLE, count=4'b0101, lap_cnt=0, wrap=0, out_valid=0, busy=0, done=0, and latched mode=00, dir=0, lap_target=0.
REQ-017 SHALL let reset override start, stop and any handshake in the same cycle, including mid-RUN.

Structure
REQ-018 SHALL have package bcd_seq_pkg hold the state enum, mode encodings, and first/last-member constants per mode and dir.
REQ-019 SHALL have one combinational sub-module bcd_seq_next (inputs: count, mode, dir; outputs: next value, is_last, is_member).
REQ-020 SHALL register all outputs except out_valid/busy/done, which decode directly from state.

Verification
REQ-021 SHALL cover: reset, start with mode=00, dir=0, lap_target=2, out_ready=1 -> count 5,7,9,5,7,9; wrap after each 9; done=1 with lap_cnt=2 and count=9.
REQ-022 SHALL cover: mode=01, dir=1, lap_target=0, out_ready=1 -> 9,7,5,3,1,9...; wrap on each 1 transfer; never DONE.
REQ-023 SHALL cover: mode=10, out_ready toggled 1,0,0,1 -> count holds at 2 for two cycles while out_valid=1, then advances to 4.
REQ-024 SHALL cover: stop asserted with out_valid&&out_ready at count=7, mode=00 -> next cycle IDLE, count=7, no wrap.
REQ-025 SHALL cover: reset asserted mid-RUN at count=8, mode=11 -> next cycle count=5, lap_cnt=0, all flags 0.
REQ-026 SHALL cover: restart from DONE with mode=11, dir=1 -> count=9, lap_cnt=0, busy=1.

Source files
------------

// File: rtl/bcd_seq_pkg.sv
// Shared types and sequence constants for the BCD sequencer.
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    ModeOddGt3 = 2'b00,  // {5,7,9}
    ModeOdd    = 2'b01,  // {1,3,5,7,9}
    ModeEven   = 2'b10,  // {0,2,4,6,8}
    ModeFull   = 2'b11   // {0..9}
  } mode_e;

  localparam logic [3:0] ResetCount = 4'd5;

  // Lowest and highest member of each sequence.
  localparam logic [3:0] OddGt3Lo = 4'd5;
  localparam logic [3:0] OddGt3Hi = 4'd9;
  localparam logic [3:0] OddLo    = 4'd1;
  localparam logic [3:0] OddHi    = 4'd9;
  localparam logic [3:0] EvenLo   = 4'd0;
  localparam logic [3:0] EvenHi   = 4'd8;
  localparam logic [3:0] FullLo   = 4'd0;
  localparam logic [3:0] FullHi   = 4'd9;

  function automatic logic [3:0] seq_lo(mode_e m);
    unique case (m)
      ModeOddGt3: seq_lo = OddGt3Lo;
      ModeOdd:    seq_lo = OddLo;
      ModeEven:   seq_lo = EvenLo;
      default:    seq_lo = FullLo;
    endcase
  endfunction

  function automatic logic [3:0] seq_hi(mode_e m);
    unique case (m)
      ModeOddGt3: seq_hi = OddGt3Hi;
      ModeOdd:    seq_hi = OddHi;
      ModeEven:   seq_hi = EvenHi;
      default:    seq_hi = FullHi;
    endcase
  endfunction

  // First member visited: lowest when ascending, highest when descending.
  function automatic logic [3:0] first_member(mode_e m, logic dir);
    first_member = dir ? seq_hi(m) : seq_lo(m);
  endfunction

  function automatic logic [3:0] last_member(mode_e m, logic dir);
    last_member = dir ? seq_lo(m) : seq_hi(m);
  endfunction

  function automatic logic [3:0] seq_step(mode_e m);
    seq_step = (m == ModeFull) ? 4'd1 : 4'd2;
  endfunction

endpackage

// File: rtl/bcd_seq_next.sv
// Combinational successor logic for the BCD sequencer.
module bcd_seq_next
  import bcd_seq_pkg::*;
(
  input  logic [3:0] count,
  input  mode_e      mode,
  input  logic       dir,
  output logic [3:0] next_count,
  output logic       is_last,
  output logic       is_member
);

  // Classify the current value and compute the next member in the chosen direction.
  always_comb begin
    is_member = 1'b0;
    unique case (mode)
      ModeOddGt3: is_member = count[0] && (count >= 4'd5) && (count <= 4'd9);
      ModeOdd:    is_member = count[0] && (count <= 4'd9);
      ModeEven:   is_member = !count[0] && (count <= 4'd8);
      default:    is_member = (count <= 4'd9);
    endcase

    is_last = is_member && (count == last_member(mode, dir));

    // Non-members and the last member both restart at the first member.
    if (!is_member || is_last) begin
      next_count = first_member(mode, dir);
    end else if (dir) begin
      next_count = count - seq_step(mode);
    end else begin
      next_count = count + seq_step(mode);
    end
  end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// BCD sequence generator with valid/ready output, lap counting and run/done control.
module bcd_seq_ctrl
  import bcd_seq_pkg::*;
#(
  parameter int unsigned LAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [LAP_W-1:0] lap_target,
  input  logic             out_ready,
  output logic [3:0]       count,
  output logic             out_valid,
  output logic             wrap,
  output logic             busy,
  output logic             done,
  output logic [LAP_W-1:0] lap_cnt
);

  state_e             state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [LAP_W-1:0]   lap_q, lap_d;
  logic               wrap_q, wrap_d;
  mode_e              mode_q, mode_d;
  logic               dir_q, dir_d;
  logic [LAP_W-1:0]   target_q, target_d;

  logic [3:0]         nxt_count;
  logic               nxt_last;
  logic               nxt_member;
  logic [LAP_W-1:0]   lap_inc;

  bcd_seq_next u_next (
    .count      (count_q),
    .mode       (mode_q),
    .dir        (dir_q),
    .next_count (nxt_count),
    .is_last    (nxt_last),
    .is_member  (nxt_member)
  );

  assign lap_inc = lap_q + LAP_W'(1);

  // Next-state logic: start/stop control, handshake advance, wrap and lap termination.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    lap_d    = lap_q;
    wrap_d   = 1'b0;
    mode_d   = mode_q;
    dir_d    = dir_q;
    target_d = target_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          mode_d   = mode_e'(mode);
          dir_d    = dir;
          target_d = lap_target;
          count_d  = first_member(mode_e'(mode), dir);
          lap_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        // Stop wins over a same-cycle transfer: the beat is consumed but not advanced.
        if (stop) begin
          state_d = StIdle;
        end else if (out_ready) begin
          if (nxt_member && nxt_last) begin
            wrap_d = 1'b1;
            lap_d  = lap_inc;
            if ((target_q != '0) && (lap_inc == target_q)) begin
              state_d = StDone;  // count keeps the last transferred value
            end else begin
              count_d = nxt_count;
            end
          end else begin
            count_d = nxt_count;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= ResetCount;
      lap_q    <= '0;
      wrap_q   <= 1'b0;
      mode_q   <= ModeOddGt3;
      dir_q    <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      lap_q    <= lap_d;
      wrap_q   <= wrap_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      target_q <= target_d;
    end
  end

  assign count     = count_q;
  assign lap_cnt   = lap_q;
  assign wrap      = wrap_q;
  assign out_valid = (state_q == StRun);
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed self-checking bench for bcd_seq_ctrl.
module tb_bcd_seq_ctrl;

  localparam int unsigned LAP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             dir = 1'b0;
  logic [LAP_W-1:0] lap_target = '0;
  logic             out_ready = 1'b0;
  logic [3:0]       count;
  logic             out_valid;
  logic             wrap;
  logic             busy;
  logic             done;
  logic [LAP_W-1:0] lap_cnt;

  int n_vec = 0;
  int n_err = 0;

  bcd_seq_ctrl #(.LAP_W(LAP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .dir        (dir),
    .lap_target (lap_target),
    .out_ready  (out_ready),
    .count      (count),
    .out_valid  (out_valid),
    .wrap       (wrap),
    .busy       (busy),
    .done       (done),
    .lap_cnt    (lap_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mode = 2'b11; dir = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    n_vec++; if (count !== 4'd5) begin n_err++; $display("FAIL reset_count got %0d want 5", count); end
    n_vec++; if (lap_cnt !== 4'd0) begin n_err++; $display("FAIL reset_lap got %0d want 0", lap_cnt); end
    n_vec++; if ({wrap, out_valid, busy, done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got %b want 0000", {wrap, out_valid, busy, done});
    end
  endtask

  task automatic test_mode00_laps();
    logic [3:0] exp_c [6] = '{4'd5, 4'd7, 4'd9, 4'd5, 4'd7, 4'd9};
    mode = 2'b00; dir = 1'b0; lap_target = 4'd2; out_ready = 1'b1; start = 1'b1;
    tick();
    // Changes outside the start cycle must be ignored.
    start = 1'b0; mode = 2'b11; dir = 1'b1; lap_target = 4'd0;
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (count !== exp_c[i]) begin
        n_err++; $display("FAIL m00_count[%0d] got %0d want %0d", i, count, exp_c[i]);
      end
      n_vec++; if (wrap !== (i == 3)) begin
        n_err++; $display("FAIL m00_wrap[%0d] got %b want %b", i, wrap, (i == 3));
      end
      n_vec++; if (lap_cnt !== ((i < 3) ? 4'd0 : 4'd1)) begin
        n_err++; $display("FAIL m00_lap[%0d] got %0d", i, lap_cnt);
      end
      n_vec++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL m00_busy[%0d] got %b%b want 11", i, busy, out_valid);
      end
      tick();
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL m00_done got %b want 1", done); end
    n_vec++; if (lap_cnt !== 4'd2) begin n_err++; $display("FAIL m00_done_lap got %0d want 2", lap_cnt); end
    n_vec++; if (count !== 4'd9) begin n_err++; $display("FAIL m00_done_count got %0d want 9", count); end
    n_vec++; if (wrap !== 1'b1) begin n_err++; $display("FAIL m00_final_wrap got %b want 1", wrap); end
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL m00_done_valid got %b%b want 00", out_valid, busy);
    end
    tick();
    n_vec++; if (wrap !== 1'b0 || done !== 1'b1) begin
      n_err++; $display("FAIL m00_done_hold got wrap=%b done=%b want 0,1", wrap, done);
    end
  endtask

  task automatic test_restart_done();
    mode = 2'b11; dir = 1'b1; lap_target = 4'd0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if (count !== 4'd9) begin n_err++; $display("FAIL restart_count got %0d want 9", count); end
    n_vec++; if (lap_cnt !== 4'd0) begin n_err++; $display("FAIL restart_lap got %0d want 0", lap_cnt); end
    n_vec++; if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL restart_state got busy=%b done=%b want 1,0", busy, done);
    end
    tick();
    n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL restart_step got %0d want 8", count); end
  endtask

  task automatic test_reset_mid_run();
    reset = 1'b1; start = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    n_vec++; if (count !== 4'd5) begin n_err++; $display("FAIL midrst_count got %0d want 5", count); end
    n_vec++; if (lap_cnt !== 4'd0) begin n_err++; $display("FAIL midrst_lap got %0d want 0", lap_cnt); end
    n_vec++; if ({wrap, out_valid, busy, done} !== 4'b0000) begin
      n_err++; $display("FAIL midrst_flags got %b want 0000", {wrap, out_valid, busy, done});
    end
    tick();
    n_vec++; if (busy !== 1'b0 || count !== 4'd5) begin
      n_err++; $display("FAIL idle_hold got busy=%b count=%0d want 0,5", busy, count);
    end
  endtask

  task automatic test_mode01_desc();
    int e;
    mode = 2'b01; dir = 1'b1; lap_target = 4'd0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e = 9 - 2 * (i % 5);
      n_vec++; if (count !== 4'(e)) begin
        n_err++; $display("FAIL m01_count[%0d] got %0d want %0d", i, count, e);
      end
      n_vec++; if (wrap !== ((i % 5 == 0) && (i != 0))) begin
        n_err++; $display("FAIL m01_wrap[%0d] got %b", i, wrap);
      end
      n_vec++; if (lap_cnt !== 4'(i / 5) || done !== 1'b0) begin
        n_err++; $display("FAIL m01_lap[%0d] got lap=%0d done=%b want %0d,0", i, lap_cnt, done, i / 5);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    mode = 2'b10; dir = 1'b0; lap_target = 4'd0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL hold_first got %0d want 0", count); end
    tick();
    n_vec++; if (count !== 4'd2) begin n_err++; $display("FAIL hold_adv got %0d want 2", count); end
    out_ready = 1'b0; start = 1'b1; mode = 2'b00; dir = 1'b1;  // start in RUN is ignored
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (count !== 4'd2 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL hold_stall[%0d] got count=%0d valid=%b want 2,1", i, count, out_valid);
      end
    end
    start = 1'b0; out_ready = 1'b1;
    tick();
    n_vec++; if (count !== 4'd4) begin n_err++; $display("FAIL hold_resume got %0d want 4", count); end
  endtask

  task automatic test_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    mode = 2'b00; dir = 1'b0; lap_target = 4'd0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_vec++; if (count !== 4'd7) begin n_err++; $display("FAIL stop_pre got %0d want 7", count); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_vec++; if (count !== 4'd7) begin n_err++; $display("FAIL stop_count got %0d want 7", count); end
    n_vec++; if ({wrap, out_valid, busy, done} !== 4'b0000) begin
      n_err++; $display("FAIL stop_flags got %b want 0000", {wrap, out_valid, busy, done});
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    n_vec++; if (busy !== 1'b0 || count !== 4'd7) begin
      n_err++; $display("FAIL startstop_idle got busy=%b count=%0d want 0,7", busy, count);
    end
    // Stop on the last member suppresses the wrap.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_vec++; if (count !== 4'd9) begin n_err++; $display("FAIL stop9_pre got %0d want 9", count); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_vec++; if (count !== 4'd9 || wrap !== 1'b0 || lap_cnt !== 4'd0) begin
      n_err++; $display("FAIL stop9 got count=%0d wrap=%b lap=%0d want 9,0,0", count, wrap, lap_cnt);
    end
  endtask

  task automatic test_done_stop();
    mode = 2'b00; dir = 1'b0; lap_target = 4'd1; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    n_vec++; if (done !== 1'b1 || count !== 4'd9 || lap_cnt !== 4'd1) begin
      n_err++; $display("FAIL done1 got done=%b count=%0d lap=%0d want 1,9,1", done, count, lap_cnt);
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    n_vec++; if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd9 || lap_cnt !== 4'd1) begin
      n_err++; $display("FAIL done_stop got done=%b busy=%b count=%0d lap=%0d want 0,0,9,1",
                        done, busy, count, lap_cnt);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_mode00_laps();
    test_restart_done();
    test_reset_mid_run();
    test_mode01_desc();
    test_hold();
    test_stop();
    test_done_stop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
